// File: rtl/adp_types.sv
// adp_types: shared ADP boundary-scan types and constants.
//   NUM_BOUNDARY_CELLS  chain length in cells
//   ADP_BSCAN_CNT_W     width of the shift-position counter k
//   adp_bscan_op_t      host scan command encoding
//   adp_bscan_state_t   scan controller sequencing states
package adp_types;

  localparam int NUM_BOUNDARY_CELLS = 49;
  localparam int ADP_BSCAN_CNT_W    = $clog2(NUM_BOUNDARY_CELLS + 1);

  typedef enum logic [1:0] {
    ADP_OP_SAMPLE   = 2'd0,
    ADP_OP_PRELOAD  = 2'd1,
    ADP_OP_EXTEST   = 2'd2,
    ADP_OP_SET_MODE = 2'd3
  } adp_bscan_op_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SHIFT   = 3'd2,
    S_UPDATE  = 3'd3,
    S_DONE    = 3'd4
  } adp_bscan_state_t;

endpackage

// File: rtl/adp_bscan_ctrl_if.sv
// adp_bscan_ctrl_if: host command / response bundle of the scan controller.
//   cmd_valid/cmd_ready  one-shot command handshake
//   cmd_op/mode/data     command payload (data bit i -> cell i)
//   rsp_done             one-cycle completion pulse
//   rsp_data             captured vector (bit i = cell i)
// Modports: master = debug host side, slave = adp_bscan_ctrl.
interface adp_bscan_ctrl_if
  import adp_types::*;
#(
  parameter int N = NUM_BOUNDARY_CELLS
);
  logic          cmd_valid;
  logic          cmd_ready;
  adp_bscan_op_t cmd_op;
  logic          cmd_mode;
  logic [N-1:0]  cmd_data;
  logic          rsp_done;
  logic [N-1:0]  rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_mode, cmd_data,
    input  cmd_ready, rsp_done, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mode, cmd_data,
    output cmd_ready, rsp_done, rsp_data
  );
endinterface

// File: rtl/adp_bscan_shifter.sv
// adp_bscan_shifter: serial datapath of the scan controller.
//   clk, rst     scan clock, sync active-high reset
//   load         command handshake; latches load_data
//   load_data    command preload vector
//   shift_nxt    next cycle is a SHIFT cycle
//   k_nxt        shift position of the next cycle
//   shifting     current cycle is a SHIFT cycle
//   k            shift position of the current cycle
//   chain_end    chain serial output
//   start        registered chain serial input
//   rsp_data     deserialized response vector
module adp_bscan_shifter #(
  parameter int N  = 49,
  parameter int KW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [N-1:0]  load_data,
  input  logic          shift_nxt,
  input  logic [KW-1:0] k_nxt,
  input  logic          shifting,
  input  logic [KW-1:0] k,
  input  logic          chain_end,
  output logic          start,
  output logic [N-1:0]  rsp_data
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  data_q;
  logic [N-1:0]  rsp_q;
  logic          start_q;
  logic [N-1:0]  src;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] idx;

  // PRELOAD enters SHIFT straight from the handshake edge, so the first
  // serial bit must come from the incoming vector, not the latched copy.
  assign src     = load ? load_data : data_q;
  // Highest cell goes first: after N shifts bit i sits in cell i.
  assign idx_nxt = IW'(KW'(N - 1) - k_nxt);
  assign idx     = IW'(KW'(N - 1) - k);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      rsp_q   <= '0;
      start_q <= 1'b0;
    end else begin
      if (load) data_q <= load_data;
      start_q <= shift_nxt ? src[idx_nxt] : 1'b0;
      // Chain end is sampled before this cycle's shift edge moves it.
      if (shifting) rsp_q[idx] <= chain_end;
    end
  end

  assign start    = start_q;
  assign rsp_data = rsp_q;
endmodule

// File: rtl/adp_bscan_ctrl.sv
// adp_bscan_ctrl: sequencing controller for the ADP boundary-scan chain.
//   clk, rst              scan clock, sync active-high reset
//   bus (slave)           host command / response handshake
//   test_mode             current output-select state
//   adp_bscan_start       chain serial input
//   adp_bscan_se          shift-register clock enable
//   adp_bscan_oe          update-latch enable
//   adp_bscan_shift_sel   1 = shift, 0 = capture
//   adp_bscan_out_sel     1 = cells drive update latches
//   adp_bscan_end         chain serial output
//   op_count              saturating count of UPDATE cycles, present only
//                         with ADP_BSCAN_CNT_EN defined, else constant 0
module adp_bscan_ctrl
  import adp_types::*;
#(
  parameter int N = NUM_BOUNDARY_CELLS
) (
  input  logic              clk,
  input  logic              rst,
  adp_bscan_ctrl_if.slave   bus,
  output logic              test_mode,
  output logic              adp_bscan_start,
  output logic              adp_bscan_se,
  output logic              adp_bscan_oe,
  output logic              adp_bscan_shift_sel,
  output logic              adp_bscan_out_sel,
  input  logic              adp_bscan_end,
  output logic [15:0]       op_count
);
  localparam int KW = $clog2(N + 1);

  adp_bscan_state_t state, state_nxt;
  adp_bscan_op_t    op_q;
  logic [KW-1:0]    k, k_nxt;
  logic             hs;
  logic             test_mode_q;
  logic             se_q, oe_q, shift_sel_q;

  assign hs = bus.cmd_valid && (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (hs) begin
          unique case (bus.cmd_op)
            ADP_OP_SAMPLE,
            ADP_OP_EXTEST:  state_nxt = S_CAPTURE;
            ADP_OP_PRELOAD: state_nxt = S_SHIFT;
            default:        state_nxt = S_DONE;
          endcase
        end
      end
      S_CAPTURE: state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (k == KW'(N - 1))
          state_nxt = (op_q == ADP_OP_SAMPLE) ? S_DONE : S_UPDATE;
      end
      S_UPDATE: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // k restarts at 0 on every SHIFT entry.
  assign k_nxt = (state == S_SHIFT && state_nxt == S_SHIFT) ? k + KW'(1) : '0;

  // Strobes are registered from the next state so they line up exactly
  // with the state they decode, with no combinational glitching.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= ADP_OP_SAMPLE;
      k           <= '0;
      test_mode_q <= 1'b0;
      se_q        <= 1'b0;
      oe_q        <= 1'b0;
      shift_sel_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      if (hs) op_q <= bus.cmd_op;
      if (hs && bus.cmd_op == ADP_OP_SET_MODE) test_mode_q <= bus.cmd_mode;
      se_q        <= (state_nxt == S_CAPTURE) || (state_nxt == S_SHIFT);
      shift_sel_q <= (state_nxt == S_SHIFT);
      oe_q        <= (state_nxt == S_UPDATE);
    end
  end

  adp_bscan_shifter #(.N(N), .KW(KW)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (hs),
    .load_data (bus.cmd_data),
    .shift_nxt (state_nxt == S_SHIFT),
    .k_nxt     (k_nxt),
    .shifting  (state == S_SHIFT),
    .k         (k),
    .chain_end (adp_bscan_end),
    .start     (adp_bscan_start),
    .rsp_data  (bus.rsp_data)
  );

`ifdef ADP_BSCAN_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (state == S_UPDATE && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end
  assign op_count = cnt_q;
`else
  assign op_count = '0;
`endif

  assign bus.cmd_ready       = (state == S_IDLE);
  assign bus.rsp_done        = (state == S_DONE);
  assign test_mode           = test_mode_q;
  assign adp_bscan_out_sel   = test_mode_q;
  assign adp_bscan_se        = se_q;
  assign adp_bscan_oe        = oe_q;
  assign adp_bscan_shift_sel = shift_sel_q;
endmodule

// File: tb/tb_adp_bscan_ctrl.sv
// Bench for adp_bscan_ctrl with a behavioral boundary-scan chain model.
// Stimulus pushes expected completions into a queue; a monitor pops and
// compares on every rsp_done. Counter scenario enabled by ADP_BSCAN_CNT_EN.
module tb_adp_bscan_ctrl;
  import adp_types::*;

  localparam int N = NUM_BOUNDARY_CELLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adp_bscan_ctrl_if #(.N(N)) bus ();

  logic        test_mode, b_start, b_se, b_oe, b_shift_sel, b_out_sel, b_end;
  logic [15:0] op_count;

  adp_bscan_ctrl #(.N(N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .test_mode           (test_mode),
    .adp_bscan_start     (b_start),
    .adp_bscan_se        (b_se),
    .adp_bscan_oe        (b_oe),
    .adp_bscan_shift_sel (b_shift_sel),
    .adp_bscan_out_sel   (b_out_sel),
    .adp_bscan_end       (b_end),
    .op_count            (op_count)
  );

  // Chain model: start enters cell 0, cell N-1 feeds the chain end.
  logic [N-1:0] pins_in = '0;
  logic [N-1:0] sr, upd, bufv;
  always @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      upd <= '0;
    end else begin
      if (b_se) sr <= b_shift_sel ? {sr[N-2:0], b_start} : pins_in;
      if (b_oe) upd <= sr;
    end
  end
  assign b_end = sr[N-1];
  assign bufv  = b_out_sel ? upd : pins_in;

  typedef struct {
    logic [N-1:0] rsp;
    int           done_cyc;
    int           oe_cyc;
    logic [N-1:0] upd;
    logic [N-1:0] bufv;
    logic         mode;
    logic [15:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   oe_since = 0;
  int   oe_total = 0;
  int   last_oe = -1;
  int   exp_oe_total = 0;
  logic [15:0] exp_cnt = '0;
  logic        cur_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (b_oe) begin
      oe_since++;
      oe_total++;
      last_oe = cyc;
    end
    if (bus.rsp_done) begin
      if (q.size() == 0) begin
        chk("spurious_done", {63'd0, bus.rsp_done}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        chk("rsp_data", 64'(bus.rsp_data), 64'(e.rsp));
        chk("oe_pulses", 64'(oe_since), (e.oe_cyc >= 0) ? 64'd1 : 64'd0);
        if (e.oe_cyc >= 0) chk("oe_cycle", 64'(last_oe), 64'(e.oe_cyc));
        chk("update_latch", 64'(upd), 64'(e.upd));
        chk("pin_buf", 64'(bufv), 64'(e.bufv));
        chk("out_sel", {63'd0, b_out_sel}, {63'd0, e.mode});
        chk("test_mode", {63'd0, test_mode}, {63'd0, e.mode});
        chk("op_count", 64'(op_count), 64'(e.cnt));
        oe_since = 0;
      end
    end
  end

  // lat / oe_lat relative to the handshake cycle; oe_lat < 0 = no UPDATE.
  task automatic issue(input adp_bscan_op_t op, input logic mode, input logic [N-1:0] data,
                       input bit track, input logic [N-1:0] exp_rsp, input int lat,
                       input int oe_lat, input logic [N-1:0] exp_upd);
    int   guard = 0;
    exp_t e;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mode  = mode;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      chk("ready_timeout", {63'd0, bus.cmd_ready}, 64'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (op == ADP_OP_SET_MODE) cur_mode = mode;
    if (oe_lat >= 0) begin
      exp_oe_total++;
`ifdef ADP_BSCAN_CNT_EN
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
    end
    if (track) begin
      e.rsp      = exp_rsp;
      e.done_cyc = cyc + lat;
      e.oe_cyc   = (oe_lat >= 0) ? cyc + oe_lat : -1;
      e.upd      = exp_upd;
      e.bufv     = cur_mode ? exp_upd : pins_in;
      e.mode     = cur_mode;
      e.cnt      = exp_cnt;
      q.push_back(e);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  localparam logic [N-1:0] D1   = 49'h1_5555_5555_5555;
  localparam logic [N-1:0] D2   = 49'h0_AAAA_0000_FFFF;
  localparam logic [N-1:0] D3   = 49'h1_2345_6789_ABCD;
  localparam logic [N-1:0] D4   = 49'h0_0F0F_1234_ABCD;
  localparam logic [N-1:0] D5   = 49'h1_FFFF_0000_0001;
  localparam logic [N-1:0] ONES = {N{1'b1}};

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ADP_OP_SAMPLE;
    bus.cmd_mode  = 1'b0;
    bus.cmd_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_strobes", {60'd0, b_se, b_oe, b_shift_sel, b_start}, 64'd0);
    end
    chk("rst_ready", {63'd0, bus.cmd_ready}, 64'd1);
    chk("rst_out_sel", {63'd0, b_out_sel}, 64'd0);
    chk("rst_test_mode", {63'd0, test_mode}, 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_done", {63'd0, bus.rsp_done}, 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);

    // EXTEST, all inputs high
    pins_in = ONES;
    issue(ADP_OP_EXTEST, 1'b0, D1, 1'b1, ONES, 52, 51, D1);
    // SET_MODE 1, then back-to-back EXTEST driving pins from latches
    issue(ADP_OP_SET_MODE, 1'b1, '0, 1'b1, ONES, 1, -1, D1);
    issue(ADP_OP_EXTEST, 1'b0, D2, 1'b1, ONES, 52, 51, D2);
    issue(ADP_OP_SET_MODE, 1'b0, '0, 1'b1, ONES, 1, -1, D2);
    drain();

    // SAMPLE with in[0]=1, in[48]=0
    pins_in = N'(1);
    issue(ADP_OP_SAMPLE, 1'b0, D3, 1'b1, N'(1), 51, -1, D2);
    drain();

    // EXTEST aborted by reset at SHIFT k=20 (cycle 22)
    issue(ADP_OP_EXTEST, 1'b0, D1, 1'b0, '0, 0, -1, '0);
    repeat (22) @(negedge clk);
    chk("abort_in_shift", {62'd0, b_se, b_shift_sel}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt  = '0;
    cur_mode = 1'b0;
    chk("abort_ready", {63'd0, bus.cmd_ready}, 64'd1);
    chk("abort_strobes", {60'd0, b_se, b_oe, b_shift_sel, b_start}, 64'd0);
    chk("abort_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("abort_rsp_done", {63'd0, bus.rsp_done}, 64'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_oe", 64'(oe_total), 64'(exp_oe_total));

    // Fresh PRELOADs: chain was cleared, second returns the first's data
    issue(ADP_OP_PRELOAD, 1'b0, D4, 1'b1, '0, 51, 50, D4);
    issue(ADP_OP_PRELOAD, 1'b0, D5, 1'b1, D4, 51, 50, D5);
    drain();

`ifdef ADP_BSCAN_CNT_EN
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.cnt_q;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++)
      issue(ADP_OP_EXTEST, 1'b0, D1, 1'b1, N'(1), 52, 51, D1);
    drain();
    chk("cnt_saturated", 64'(op_count), 64'hFFFF);
`endif

    repeat (5) @(negedge clk);
    chk("oe_total", 64'(oe_total), 64'(exp_oe_total));
    chk("queue_left", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
